// File: rtl/freq_gate_if.sv
// Handshake and data bundle between the measurement sequencer, the edge counter and the display path.
// master = host/counter side, slave = sequencer side.
interface freq_gate_if #(
   parameter int BIT_SIZE = 20
);
   logic                start;
   logic                cont;
   logic                auto_en;
   logic [1:0]          range_sel;
   logic [BIT_SIZE-1:0] cnt_value;
   logic                cnt_ovf;
   logic                cnt_clr;
   logic                cnt_en;
   logic [BIT_SIZE-1:0] result;
   logic [1:0]          range;
   logic                result_valid;
   logic                overrange;
   logic                busy;

   modport master (
      output start, cont, auto_en, range_sel, cnt_value, cnt_ovf,
      input  cnt_clr, cnt_en, result, range, result_valid, overrange, busy
   );

   modport slave (
      input  start, cont, auto_en, range_sel, cnt_value, cnt_ovf,
      output cnt_clr, cnt_en, result, range, result_valid, overrange, busy
   );
endinterface

// File: rtl/freq_gate_controller.sv
// Frequency meter sequencer: clears the edge counter, opens an exact gate window,
// then latches the count and auto-ranges the gate time to fit six display digits.
//
// state  | meaning
// IDLE   | waiting for start or cont
// CLEAR  | one-cycle counter clear, working range settled
// GATE   | counter enabled for the gate length of the working range
// SETTLE | two cycles for in-flight edges to land in the counter
// EVAL   | sample count, publish or step range up and retry
module freq_gate_controller #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BIT_SIZE   = 20,
   parameter int MAX_COUNT  = 999_999,
   parameter int LOW_THRESH = 90_000
) (
   input logic        clk,
   input logic        rst,
   freq_gate_if.slave bus
);

   localparam int GW = $clog2(CLK_FREQ + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_GATE,
      S_SETTLE,
      S_EVAL
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       gate_q, gate_d;
   logic                settle_q, settle_d;
   logic [1:0]          wrange_q, wrange_d;
   logic [BIT_SIZE-1:0] result_q, result_d;
   logic [1:0]          range_q, range_d;
   logic                ovr_q, ovr_d;
   logic                valid_q, valid_d;

   logic [1:0]          sel_clamped;
   logic                big;

   // Gate counter is loaded with length-1 and counts down to terminal zero.
   function automatic logic [GW-1:0] gate_load(input logic [1:0] r);
      case (r)
         2'd0:    gate_load = GW'(CLK_FREQ - 1);
         2'd1:    gate_load = GW'(CLK_FREQ / 10 - 1);
         default: gate_load = GW'(CLK_FREQ / 100 - 1);
      endcase
   endfunction

   assign sel_clamped = (bus.range_sel == 2'd3) ? 2'd2 : bus.range_sel;
   assign big         = bus.cnt_ovf || (bus.cnt_value > BIT_SIZE'(MAX_COUNT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         gate_q   <= '0;
         settle_q <= 1'b0;
         wrange_q <= 2'd0;
         result_q <= '0;
         range_q  <= 2'd0;
         ovr_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         gate_q   <= gate_d;
         settle_q <= settle_d;
         wrange_q <= wrange_d;
         result_q <= result_d;
         range_q  <= range_d;
         ovr_q    <= ovr_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gate_d   = gate_q;
      settle_d = settle_q;
      wrange_d = wrange_q;
      result_d = result_q;
      range_d  = range_q;
      ovr_d    = ovr_q;
      valid_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start || bus.cont) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            if (!bus.auto_en) wrange_d = sel_clamped;
            gate_d  = gate_load(wrange_d);
            state_d = S_GATE;
         end
         S_GATE: begin
            if (gate_q == '0) begin
               settle_d = 1'b0;
               state_d  = S_SETTLE;
            end else begin
               gate_d = gate_q - 1'b1;
            end
         end
         S_SETTLE: begin
            if (settle_q) state_d = S_EVAL;
            else          settle_d = 1'b1;
         end
         S_EVAL: begin
            if (big && bus.auto_en && (wrange_q < 2'd2)) begin
               wrange_d = wrange_q + 2'd1;
               state_d  = S_CLEAR;
            end else begin
               valid_d = 1'b1;
               range_d = wrange_q;
               if (big) begin
                  result_d = BIT_SIZE'(MAX_COUNT);
                  ovr_d    = 1'b1;
               end else begin
                  result_d = bus.cnt_value;
                  ovr_d    = 1'b0;
                  // Hysteresis: only step down when well below a full display.
                  if (bus.auto_en && (wrange_q != 2'd0) &&
                      (bus.cnt_value < BIT_SIZE'(LOW_THRESH)))
                     wrange_d = wrange_q - 2'd1;
               end
               state_d = bus.cont ? S_CLEAR : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.cnt_clr      = (state_q == S_CLEAR);
   assign bus.cnt_en       = (state_q == S_GATE);
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.result       = result_q;
   assign bus.range        = range_q;
   assign bus.overrange    = ovr_q;
   assign bus.result_valid = valid_q;

endmodule
